// File: rtl/gearbox_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : gearbox_sequencer
//  Purpose  : 16-bit to 10-bit symbol gearbox sequencer on the receive path.
//             Accepts 16-bit words over valid/ready and emits zero, one or
//             two 10-bit symbols per word; five words yield eight symbols.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk          in   1   clock
//    rst          in   1   synchronous active-high reset
//    in_data      in  16   input word
//    in_valid     in   1   in_data valid
//    in_ready     out  1   a word can be accepted this cycle
//    sym0         out 10   earlier output symbol
//    sym1         out 10   later output symbol (0 when sym1_valid=0)
//    sym0_valid   out  1   sym0 holds a symbol
//    sym1_valid   out  1   sym1 holds a symbol
//    out_ready    in   1   downstream accepts the symbol pair
//    phase        out  3   phase the next accepted word will use (0..4)
//    frame_start  out  1   presented pair came from a phase-0 word
//    align        in   1   only when GEARBOX_SEQ_ALIGN_EN is defined:
//                          forces phase 0 with an empty residual
//
//  Parameters
//    LSB_FIRST    1: bit 0 of a word is the earliest wire bit
//                 0: each word is bit-reversed before accumulation
//
//  Build option macro: GEARBOX_SEQ_ALIGN_EN
// ============================================================================
module gearbox_sequencer #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [9:0]  sym0,
    output logic [9:0]  sym1,
    output logic        sym0_valid,
    output logic        sym1_valid,
    input  logic        out_ready,
    output logic [2:0]  phase,
    output logic        frame_start
`ifdef GEARBOX_SEQ_ALIGN_EN
    ,
    input  logic        align
`endif
);

    localparam logic [2:0] c_PHASE_0 = 3'd0;
    localparam logic [2:0] c_PHASE_1 = 3'd1;
    localparam logic [2:0] c_PHASE_2 = 3'd2;
    localparam logic [2:0] c_PHASE_3 = 3'd3;
    localparam logic [2:0] c_PHASE_4 = 3'd4;

    logic [7:0]  r_res;
    logic [2:0]  r_phase;
    logic [9:0]  r_sym0;
    logic [9:0]  r_sym1;
    logic        r_v0;
    logic        r_v1;
    logic        r_fs;

    logic [15:0] w_word;
    logic        w_align;
    logic        w_in_ready;
    logic        w_accept;
    logic [2:0]  w_cur_phase;
    logic [7:0]  w_cur_res;
    logic [9:0]  w_nxt_sym0;
    logic [9:0]  w_nxt_sym1;
    logic        w_nxt_v1;
    logic [7:0]  w_nxt_res;
    logic [2:0]  w_nxt_phase;

    // Word ordering into the accumulator
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_word = in_data;
        end else begin : g_msb_first
            for (genvar i = 0; i < 16; i++) begin : g_rev
                assign w_word[i] = in_data[15-i];
            end
        end
    endgenerate

`ifdef GEARBOX_SEQ_ALIGN_EN
    assign w_align = align;
`else
    assign w_align = 1'b0;
`endif

    // Single output register stage: free to load when empty or being drained
    assign w_in_ready = !r_v0 || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    // Alignment makes a same-cycle word start a fresh frame
    assign w_cur_phase = w_align ? c_PHASE_0 : r_phase;
    assign w_cur_res   = w_align ? 8'd0 : r_res;

    always_comb begin
        w_nxt_sym0  = '0;
        w_nxt_sym1  = '0;
        w_nxt_v1    = 1'b0;
        w_nxt_res   = '0;
        w_nxt_phase = c_PHASE_0;
        case (w_cur_phase)
            c_PHASE_0: begin
                w_nxt_sym0  = w_word[9:0];
                w_nxt_res   = {2'b00, w_word[15:10]};
                w_nxt_phase = c_PHASE_1;
            end
            c_PHASE_1: begin
                w_nxt_sym0  = {w_word[3:0], w_cur_res[5:0]};
                w_nxt_sym1  = w_word[13:4];
                w_nxt_v1    = 1'b1;
                w_nxt_res   = {6'b000000, w_word[15:14]};
                w_nxt_phase = c_PHASE_2;
            end
            c_PHASE_2: begin
                w_nxt_sym0  = {w_word[7:0], w_cur_res[1:0]};
                w_nxt_res   = w_word[15:8];
                w_nxt_phase = c_PHASE_3;
            end
            c_PHASE_3: begin
                w_nxt_sym0  = {w_word[1:0], w_cur_res[7:0]};
                w_nxt_sym1  = w_word[11:2];
                w_nxt_v1    = 1'b1;
                w_nxt_res   = {4'b0000, w_word[15:12]};
                w_nxt_phase = c_PHASE_4;
            end
            c_PHASE_4: begin
                w_nxt_sym0  = {w_word[5:0], w_cur_res[3:0]};
                w_nxt_sym1  = w_word[15:6];
                w_nxt_v1    = 1'b1;
                w_nxt_res   = '0;
                w_nxt_phase = c_PHASE_0;
            end
            default: begin
                w_nxt_phase = c_PHASE_0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res   <= '0;
            r_phase <= c_PHASE_0;
            r_sym0  <= '0;
            r_sym1  <= '0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_fs    <= 1'b0;
        end else if (w_accept) begin
            // Covers accept-only and consume+accept (no bubble)
            r_sym0  <= w_nxt_sym0;
            r_sym1  <= w_nxt_sym1;
            r_v0    <= 1'b1;
            r_v1    <= w_nxt_v1;
            r_fs    <= (w_cur_phase == c_PHASE_0);
            r_res   <= w_nxt_res;
            r_phase <= w_nxt_phase;
        end else begin
            if (r_v0 && out_ready) begin
                r_v0   <= 1'b0;
                r_v1   <= 1'b0;
                r_sym1 <= '0;
                r_fs   <= 1'b0;
            end
            // Align without a word only resets the frame position
            if (w_align) begin
                r_phase <= c_PHASE_0;
                r_res   <= '0;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign sym0        = r_sym0;
    assign sym1        = r_sym1;
    assign sym0_valid  = r_v0;
    assign sym1_valid  = r_v1;
    assign phase       = r_phase;
    assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: doc/gearbox_sequencer.md
# gearbox_sequencer

Sequences the 16-bit to 10-bit symbol gearbox on the receive interface: accepts 16-bit words over a valid/ready handshake and emits zero, one or two 10-bit symbols per accepted word. Five accepted words (80 bits) always yield exactly eight symbols. Sits between the 16-bit input stream and the 10-bit symbol decoder. Owns the phase counter, the residual-bit store, the output-valid strobes and downstream backpressure.

## Interface
- LSB_FIRST, 1, 1: bit 0 of each word is the earliest bit on the wire. 0: each word is bit-reversed before accumulation.
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk
- rst  in  1  synchronous active-high reset
- in_data  in  16  input word
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word this cycle
- sym0  out  10  earlier output symbol
- sym1  out  10  later output symbol
- sym0_valid  out  1  sym0 holds a symbol
- sym1_valid  out  1  sym1 holds a symbol; never 1 while sym0_valid is 0
- out_ready  in  1  downstream accepts the symbol pair
- phase  out  3  phase the next accepted word will use, 0..4
- frame_start  out  1  1 when the presented pair came from a phase-0 word
- align  in  1  present only with GEARBOX_SEQ_ALIGN_EN

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !(sym0_valid) || out_ready. This is a single output register stage.
- Residual store holds 0–8 bits, earliest bit at bit 0.
- Each accepted word is appended above the residual. Symbols are then taken from the LSB end, 10 bits each.
- Phase table (phase: symbols emitted, residual after):
  - 0: 1, 6
  - 1: 2, 2
  - 2: 1, 8
  - 3: 2, 4
  - 4: 2, 0
- Phase wraps 4→0.
- Symbol contents per phase:
  - Phase 0: sym0=w[9:0]; res=w[15:10].
  - Phase 1: sym0={w[3:0],res[5:0]}, sym1=w[13:4]; res=w[15:14].
  - Phase 2: sym0={w[7:0],res[1:0]}; res=w[15:8].
  - Phase 3: sym0={w[1:0],res[7:0]}, sym1=w[11:2]; res=w[15:12].
  - Phase 4: sym0={w[5:0],res[3:0]}, sym1=w[15:6].
- Output registers are loaded on accept. They hold stable until out_ready is seen while sym0_valid=1.
- A consumed pair with no new accept clears both valids.
- Consume and accept may occur in the same cycle; the new pair replaces the old with no bubble.
- sym1 is driven 0 when sym1_valid=0.
- Residual bits, phase and output registers are never modified while in_ready=0.

## Timing
- Latency: 1 cycle from accept to sym0_valid.
- Throughput: 1 word per cycle with out_ready held at 1.
- Reset values: sym0=0, sym1=0, sym0_valid=0, sym1_valid=0, phase=0, frame_start=0, residual cleared.
- in_ready reads 1 in the first cycle after reset.
- Reset mid-frame: residual bits are discarded and the pending pair is dropped. The next word is treated as phase 0.
- in_valid with in_ready=0: no state change. Upstream must hold in_data.

## Configuration
- Macro: GEARBOX_SEQ_ALIGN_EN.
- Defined: the align port exists.
- align=1 in a cycle:
  - phase←0 and residual cleared.
  - A word accepted in the same cycle is processed as phase 0 with an empty residual.
  - The pending output pair is untouched.
  - align has priority over phase advance; rst has priority over align.
- Not defined: no port. Phase returns to 0 only via reset or natural wrap.

## Test plan
- Reset, then 5 words of 0xFFFF back-to-back with out_ready=1:
  - Valid patterns are (1,0),(1,1),(1,0),(1,1),(1,1), i.e. 8 symbols, all 0x3FF.
  - Phase sequence 1,2,3,4,0 after each accept; frame_start=1 only on the first pair.
- Reset, accept 0xABCD then 0x1234:
  - First pair sym0=0x3CD.
  - Second pair sym0=0x12A, sym1=0x123.
- Backpressure: hold out_ready=0 after the first accept.
  - in_ready=0 and sym0/sym1/valids are stable for 10 cycles.
  - Releasing out_ready consumes the pair and accepts the next word in the same cycle.
- Assert rst after 2 words, then send 0x03FF:
  - sym0=0x3FF, frame_start=1, phase=1.
- With GEARBOX_SEQ_ALIGN_EN: send 3 words, then pulse align together with word 0x0155.
  - sym0=0x155, sym1_valid=0, phase=1.
- Random in_valid/out_ready over 1000 words:
  - Symbol stream equals the serial LSB-first reference.
  - Exactly 1600 symbols are produced.
